// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier slice: loader FSM states,
// matrix selector and the bank/address width helpers.
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } mm_state_e;

    typedef enum logic {
        MAT_A = 1'b0,
        MAT_B = 1'b1
    } mm_mat_e;

    // ceil(log2(v)) with a floor of one bit, so degenerate sizes still get a port
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Address width of one A bank: each bank holds M/N_BANKS full rows of K elements
    function automatic int aw_a(input int m, input int k, input int n_banks);
        return clog2_min1(m / n_banks * k);
    endfunction

    // Address width of one B bank: each bank holds N/N_BANKS columns of K elements
    function automatic int aw_b(input int k, input int n, input int n_banks);
        return clog2_min1(k * n / n_banks);
    endfunction

endpackage

// File: rtl/mm_bank_addr_gen.sv
// Row-major (row, col) index counter for one matrix, mapped to the bank that
// owns the element and the word address inside that bank. MODE selects the
// A layout (rows interleaved over banks) or the B layout (columns interleaved).
module mm_bank_addr_gen
    import mm_pkg::*;
#(
    parameter mm_mat_e MODE    = MAT_A,
    parameter int      ROWS    = 3,
    parameter int      COLS    = 3,
    parameter int      N_BANKS = 3,
    parameter int      AW      = 2,
    localparam int     BW      = clog2_min1(N_BANKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    output logic [BW-1:0] bank,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          row_end;
    logic          col_end;
    logic [31:0]   row_w;
    logic [31:0]   col_w;

    assign row_end = (row == RW'(ROWS - 1));
    assign col_end = (col == CW'(COLS - 1));
    assign last    = row_end && col_end;
    assign row_w   = 32'(row);
    assign col_w   = 32'(col);

    // Advance the row-major index on each accepted element, wrapping at the end
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    if (MODE == MAT_A) begin : g_map_a
        // A(r,k): bank r%N_BANKS, addr (r/N_BANKS)*K + k
        assign bank = BW'(row_w % N_BANKS);
        assign addr = AW'((row_w / N_BANKS) * COLS + col_w);
    end else begin : g_map_b
        // B(k,n): bank n%N_BANKS, addr k*(N/N_BANKS) + n/N_BANKS
        assign bank = BW'(col_w % N_BANKS);
        assign addr = AW'(row_w * (COLS / N_BANKS) + col_w / N_BANKS);
    end

endmodule

// File: rtl/mm_stream_loader.sv
// Streaming front-end for the matrix multiplier: takes A then B as one
// row-major valid/ready stream, scatters the elements into the bank Port A
// interfaces, then hands the ports to the controller and runs the job.
module mm_stream_loader
    import mm_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  M          = 3,
    parameter int  K          = 3,
    parameter int  N          = 3,
    parameter int  N_BANKS    = 3,
    localparam int AW_A       = aw_a(M, K, N_BANKS),
    localparam int AW_B       = aw_b(K, N, N_BANKS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_start,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_last,
    output logic                          ctrl_start,
    input  logic                          ctrl_done,
    input  logic [N_BANKS-1:0]            ctrl_en_a,
    input  logic [N_BANKS-1:0]            ctrl_we_a,
    input  logic [N_BANKS*AW_A-1:0]       ctrl_addr_a,
    input  logic [N_BANKS*DATA_WIDTH-1:0] ctrl_din_a,
    input  logic [N_BANKS-1:0]            ctrl_en_b,
    input  logic [N_BANKS-1:0]            ctrl_we_b,
    input  logic [N_BANKS*AW_B-1:0]       ctrl_addr_b,
    input  logic [N_BANKS*DATA_WIDTH-1:0] ctrl_din_b,
    output logic [N_BANKS-1:0]            en_a_brams,
    output logic [N_BANKS-1:0]            we_a_brams,
    output logic [N_BANKS*AW_A-1:0]       addr_a_brams,
    output logic [N_BANKS*DATA_WIDTH-1:0] din_a_brams,
    output logic [N_BANKS-1:0]            en_b_brams,
    output logic [N_BANKS-1:0]            we_b_brams,
    output logic [N_BANKS*AW_B-1:0]       addr_b_brams,
    output logic [N_BANKS*DATA_WIDTH-1:0] din_b_brams,
    output logic                          busy,
    output logic                          job_done,
    output logic                          len_err
);

    localparam int BW = clog2_min1(N_BANKS);

    if ((M % N_BANKS) != 0 || (N % N_BANKS) != 0) begin : g_bad_banks
        $error("mm_stream_loader: M and N must both be multiples of N_BANKS");
    end

    mm_state_e             state;
    logic                  own_ctrl;
    logic                  beat;
    logic                  accept_start;
    logic                  step_a;
    logic                  step_b;
    logic                  final_b;
    logic [BW-1:0]         a_bank;
    logic [BW-1:0]         b_bank;
    logic [AW_A-1:0]       a_addr;
    logic [AW_B-1:0]       b_addr;
    logic                  a_last;
    logic                  b_last;

    logic                  wr_valid;
    mm_mat_e               wr_mat;
    logic [BW-1:0]         wr_bank;
    logic [AW_A-1:0]       wr_addr_a;
    logic [AW_B-1:0]       wr_addr_b;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [N_BANKS-1:0]    ld_en_a;
    logic [N_BANKS-1:0]    ld_en_b;

    assign beat         = s_valid && s_ready;
    assign accept_start = (state == ST_IDLE) && load_start;
    assign step_a       = beat && (state == ST_LOAD_A);
    assign step_b       = beat && (state == ST_LOAD_B);
    assign final_b      = step_b && b_last;

    mm_bank_addr_gen #(
        .MODE    (MAT_A),
        .ROWS    (M),
        .COLS    (K),
        .N_BANKS (N_BANKS),
        .AW      (AW_A)
    ) u_addr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_start),
        .step  (step_a),
        .bank  (a_bank),
        .addr  (a_addr),
        .last  (a_last)
    );

    mm_bank_addr_gen #(
        .MODE    (MAT_B),
        .ROWS    (K),
        .COLS    (N),
        .N_BANKS (N_BANKS),
        .AW      (AW_B)
    ) u_addr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_start || (step_a && a_last)),
        .step  (step_b),
        .bank  (b_bank),
        .addr  (b_addr),
        .last  (b_last)
    );

    // Job sequencer with registered handshake outputs and Port A ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            ctrl_start <= 1'b0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            own_ctrl   <= 1'b0;
        end else begin
            job_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state   <= ST_LOAD_A;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD_A: begin
                    if (step_a && a_last) state <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    if (final_b) begin
                        state   <= ST_DRAIN;
                        s_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state      <= ST_RUN;
                    ctrl_start <= 1'b1;
                    own_ctrl   <= 1'b1;
                end
                ST_RUN: begin
                    if (ctrl_done) begin
                        state      <= ST_DONE;
                        ctrl_start <= 1'b0;
                        job_done   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    own_ctrl <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    s_ready    <= 1'b0;
                    ctrl_start <= 1'b0;
                    busy       <= 1'b0;
                    own_ctrl   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky stream-length error: s_last must mark exactly the final B element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err <= 1'b0;
        end else if (accept_start) begin
            len_err <= 1'b0;
        end else if ((beat && s_last && !final_b) || (final_b && !s_last)) begin
            len_err <= 1'b1;
        end
    end

    // Capture each accepted element so its bank write lands on the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: address/data registers are reset too, so every bank output reads 0 in reset.
        if (!rst_n) begin
            wr_valid  <= 1'b0;
            wr_mat    <= MAT_A;
            wr_bank   <= '0;
            wr_addr_a <= '0;
            wr_addr_b <= '0;
            wr_data   <= '0;
        end else begin
            wr_valid <= beat;
            if (beat) begin
                wr_mat    <= (state == ST_LOAD_B) ? MAT_B : MAT_A;
                wr_bank   <= (state == ST_LOAD_B) ? b_bank : a_bank;
                wr_addr_a <= a_addr;
                wr_addr_b <= b_addr;
                wr_data   <= s_data;
            end
        end
    end

    // Decode the pending write into a one-hot bank enable for the target matrix
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        ld_en_a = '0;
        ld_en_b = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            ld_en_a[i] = wr_valid && (wr_mat == MAT_A) && (wr_bank == BW'(i));
            ld_en_b[i] = wr_valid && (wr_mat == MAT_B) && (wr_bank == BW'(i));
        end
    end

    // Port A mux: controller owns the banks from RUN entry to DONE exit
    assign en_a_brams   = own_ctrl ? ctrl_en_a   : ld_en_a;
    assign we_a_brams   = own_ctrl ? ctrl_we_a   : ld_en_a;
    assign addr_a_brams = own_ctrl ? ctrl_addr_a : {N_BANKS{wr_addr_a}};
    assign din_a_brams  = own_ctrl ? ctrl_din_a  : {N_BANKS{wr_data}};
    assign en_b_brams   = own_ctrl ? ctrl_en_b   : ld_en_b;
    assign we_b_brams   = own_ctrl ? ctrl_we_b   : ld_en_b;
    assign addr_b_brams = own_ctrl ? ctrl_addr_b : {N_BANKS{wr_addr_b}};
    assign din_b_brams  = own_ctrl ? ctrl_din_b  : {N_BANKS{wr_data}};

endmodule

// File: tb/tb_mm_stream_loader.sv
// Directed bench for mm_stream_loader: a 3x3 instance checked through a write
// scoreboard and handshake timing, plus a 6x6 instance for the address map.
module tb_mm_stream_loader;

    localparam int DW = 16;

    typedef struct {
        int due;
        bit is_b;
        int bank;
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 3x3 instance
    logic          load_start, s_valid, s_last, ctrl_done;
    logic [DW-1:0] s_data;
    logic          s_ready, ctrl_start, busy, job_done, len_err;
    logic [2:0]    ctrl_en_a, ctrl_we_a, ctrl_en_b, ctrl_we_b;
    logic [5:0]    ctrl_addr_a, ctrl_addr_b;
    logic [47:0]   ctrl_din_a, ctrl_din_b;
    logic [2:0]    en_a_brams, we_a_brams, en_b_brams, we_b_brams;
    logic [5:0]    addr_a_brams, addr_b_brams;
    logic [47:0]   din_a_brams, din_b_brams;

    // 6x3 * 3x6 instance
    logic          load_start2, s_valid2, s_last2;
    logic [DW-1:0] s_data2;
    logic          s_ready2, ctrl_start2, busy2, job_done2, len_err2;
    logic [2:0]    en_a2, we_a2, en_b2, we_b2;
    logic [8:0]    addr_a2, addr_b2;
    logic [47:0]   din_a2, din_b2;

    wr_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  mem_a[3][3];
    int  mem_b[3][3];
    int  mem2_a[3][8];
    int  mem2_b[3][8];

    mm_stream_loader #(
        .DATA_WIDTH(DW), .M(3), .K(3), .N(3), .N_BANKS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
        .ctrl_en_a(ctrl_en_a), .ctrl_we_a(ctrl_we_a),
        .ctrl_addr_a(ctrl_addr_a), .ctrl_din_a(ctrl_din_a),
        .ctrl_en_b(ctrl_en_b), .ctrl_we_b(ctrl_we_b),
        .ctrl_addr_b(ctrl_addr_b), .ctrl_din_b(ctrl_din_b),
        .en_a_brams(en_a_brams), .we_a_brams(we_a_brams),
        .addr_a_brams(addr_a_brams), .din_a_brams(din_a_brams),
        .en_b_brams(en_b_brams), .we_b_brams(we_b_brams),
        .addr_b_brams(addr_b_brams), .din_b_brams(din_b_brams),
        .busy(busy), .job_done(job_done), .len_err(len_err)
    );

    mm_stream_loader #(
        .DATA_WIDTH(DW), .M(6), .K(3), .N(6), .N_BANKS(3)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_last(s_last2),
        .ctrl_start(ctrl_start2), .ctrl_done(1'b0),
        .ctrl_en_a(3'b0), .ctrl_we_a(3'b0), .ctrl_addr_a(9'b0), .ctrl_din_a(48'b0),
        .ctrl_en_b(3'b0), .ctrl_we_b(3'b0), .ctrl_addr_b(9'b0), .ctrl_din_b(48'b0),
        .en_a_brams(en_a2), .we_a_brams(we_a2), .addr_a_brams(addr_a2), .din_a_brams(din_a2),
        .en_b_brams(en_b2), .we_b_brams(we_b2), .addr_b_brams(addr_b2), .din_b_brams(din_b2),
        .busy(busy2), .job_done(job_done2), .len_err(len_err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the 3x3 instance: each beat expects one write next cycle
    always @(negedge clk) begin : mon1
        wr_t        w;
        logic [5:0] exp_en;
        if (rst_n) begin
            if (sb.size() > 0) begin
                vectors++;
                assert (sb[0].due >= cyc) else begin
                    miscompares++;
                    $error("FAIL sb_late: write due cycle %0d not seen by cycle %0d", sb[0].due, cyc);
                    void'(sb.pop_front());
                end
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                w = sb.pop_front();
                exp_en = w.is_b ? (6'b1 << (w.bank + 3)) : (6'b1 << w.bank);
                check("wr_en", {en_b_brams, en_a_brams}, exp_en);
                check("wr_we", {we_b_brams, we_a_brams}, exp_en);
                if (w.is_b) begin
                    check("wr_addr_b", addr_b_brams[w.bank*2 +: 2], w.addr);
                    check("wr_din_b", din_b_brams[w.bank*16 +: 16], w.data);
                    mem_b[w.bank][w.addr] = int'(din_b_brams[w.bank*16 +: 16]);
                end else begin
                    check("wr_addr_a", addr_a_brams[w.bank*2 +: 2], w.addr);
                    check("wr_din_a", din_a_brams[w.bank*16 +: 16], w.data);
                    mem_a[w.bank][w.addr] = int'(din_a_brams[w.bank*16 +: 16]);
                end
            end else begin
                check("no_wr", {en_b_brams, en_a_brams, we_b_brams, we_a_brams}, 12'h0);
            end
        end
    end

    // Bank image builder for the 6x6 instance
    always @(negedge clk) begin
        if (rst_n) begin
            for (int b = 0; b < 3; b++) begin
                if (en_a2[b]) mem2_a[b][addr_a2[b*3 +: 3]] = int'(din_a2[b*16 +: 16]);
                if (en_b2[b]) mem2_b[b][addr_b2[b*3 +: 3]] = int'(din_b2[b*16 +: 16]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int data, input bit last, input bit is_b, input int bank, input int addr);
        bit  got;
        wr_t w;
        got = 1'b0;
        s_valid = 1'b1;
        s_data  = DW'(data);
        s_last  = last;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (s_ready) begin
                w.due = cyc + 1; w.is_b = is_b; w.bank = bank; w.addr = addr; w.data = data;
                sb.push_back(w);
                got = 1'b1;
            end else begin
                tick();
            end
        end
        check("send_accepted", got, 1'b1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send2(input int data, input bit last);
        bit got;
        got = 1'b0;
        s_valid2 = 1'b1;
        s_data2  = DW'(data);
        s_last2  = last;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (s_ready2) got = 1'b1;
            else tick();
        end
        check("send2_accepted", got, 1'b1);
        tick();
        s_valid2 = 1'b0;
        s_last2  = 1'b0;
    endtask

    task automatic start_job();
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        @(negedge clk);
        check("start_ready", {s_ready, busy, len_err, ctrl_start}, 4'b1100);
        tick();
    endtask

    // Stream the first n_beats elements of A=1..9, B=10..18; s_last on index last_pos
    task automatic load_job(input bit gaps, input int last_pos, input int n_beats);
        int  j, r, c, bank, addr;
        bit  is_b;
        for (int i = 0; i < n_beats; i++) begin
            is_b = (i >= 9);
            j = i % 9;
            r = j / 3;
            c = j % 3;
            if (!is_b) begin
                bank = r % 3;
                addr = (r / 3) * 3 + c;
            end else begin
                bank = c % 3;
                addr = r * 1 + c / 3;
            end
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1) == 1; g++) tick();
            end
            send(is_b ? 10 + j : 1 + j, i == last_pos, is_b, bank, addr);
            if (i == last_pos && i != 17) check("len_err_early", len_err, 1'b1);
        end
    endtask

    // DRAIN -> RUN -> DONE -> IDLE, with ctrl passthrough and optional ignored load_start
    task automatic finish_job(input bit poke);
        @(negedge clk);
        check("drain_state", {ctrl_start, busy, s_ready, job_done}, 4'b0100);
        tick();
        @(negedge clk);
        check("run_ctrl_start", {ctrl_start, busy, s_ready}, 3'b110);
        #1;
        ctrl_en_a = 3'b010; ctrl_we_a = 3'b010; ctrl_addr_a = 6'b00_10_00;
        ctrl_din_a = 48'h0000_BEEF_0000;
        ctrl_en_b = 3'b100; ctrl_we_b = 3'b000; ctrl_addr_b = 6'b01_00_00;
        ctrl_din_b = 48'h1234_0000_0000;
        #1;
        check("pass_en_a", {en_a_brams, we_a_brams}, 6'b010_010);
        check("pass_addr_a", addr_a_brams, 6'h08);
        check("pass_din_a", din_a_brams, 48'h0000_BEEF_0000);
        check("pass_en_b", {en_b_brams, we_b_brams}, 6'b100_000);
        check("pass_addr_b", addr_b_brams, 6'h10);
        check("pass_din_b", din_b_brams, 48'h1234_0000_0000);
        #1;
        ctrl_en_a = '0; ctrl_we_a = '0; ctrl_addr_a = '0; ctrl_din_a = '0;
        ctrl_en_b = '0; ctrl_we_b = '0; ctrl_addr_b = '0; ctrl_din_b = '0;
        if (poke) begin
            tick();
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
            @(negedge clk);
            check("run_ignores_start", {ctrl_start, busy, s_ready, job_done}, 4'b1100);
        end
        tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        @(negedge clk);
        check("done_pulse", {job_done, ctrl_start, busy}, 3'b101);
        tick();
        @(negedge clk);
        check("back_idle", {job_done, ctrl_start, busy, s_ready}, 4'b0000);
    endtask

    task automatic clear_mem();
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < 3; a++) begin
                mem_a[b][a] = -1;
                mem_b[b][a] = -1;
            end
    endtask

    task automatic check_mem(input string tag);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                check({tag, "_a"}, mem_a[r % 3][(r / 3) * 3 + c], 1 + r * 3 + c);
                check({tag, "_b"}, mem_b[c % 3][r + c / 3], 10 + r * 3 + c);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        load_start = 0; s_valid = 0; s_last = 0; s_data = '0; ctrl_done = 0;
        ctrl_en_a = '0; ctrl_we_a = '0; ctrl_addr_a = '0; ctrl_din_a = '0;
        ctrl_en_b = '0; ctrl_we_b = '0; ctrl_addr_b = '0; ctrl_din_b = '0;
        load_start2 = 0; s_valid2 = 0; s_last2 = 0; s_data2 = '0;
        clear_mem();
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < 8; a++) begin
                mem2_a[b][a] = -1;
                mem2_b[b][a] = -1;
            end

        // Reset values
        #12;
        check("rst_ctrl", {s_ready, ctrl_start, busy, job_done, len_err}, 5'b0);
        check("rst_en", {en_a_brams, we_a_brams, en_b_brams, we_b_brams}, 12'h0);
        check("rst_ctrl2", {s_ready2, ctrl_start2, busy2, job_done2, len_err2}, 5'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Idle: controller requests do not reach the banks
        ctrl_en_a = 3'b111; ctrl_en_b = 3'b111;
        #1;
        check("idle_no_pass", {en_a_brams, en_b_brams}, 6'b0);
        ctrl_en_a = '0; ctrl_en_b = '0;

        // 6x3 * 3x6 address map
        tick();
        load_start2 = 1'b1;
        tick();
        load_start2 = 1'b0;
        for (int i = 0; i < 36; i++) send2(i < 18 ? 100 + i : 200 + (i - 18), i == 35);
        tick(); tick();
        check("map_a_r4k2", mem2_a[1][5], 114);
        check("map_b_k1n5", mem2_b[2][3], 211);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++)
                check("map_a_all", mem2_a[r % 3][(r / 3) * 3 + c], 100 + r * 3 + c);
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 6; n++)
                check("map_b_all", mem2_b[n % 3][k * 2 + n / 3], 200 + k * 6 + n);
        check("map_len_err", len_err2, 1'b0);

        // Basic 3x3 job; ctrl_done in LOAD_A and load_start in RUN are ignored
        start_job();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        @(negedge clk);
        check("loada_ignores_done", {s_ready, busy, ctrl_start, job_done}, 4'b1100);
        tick();
        load_job(1'b0, 17, 18);
        finish_job(1'b1);
        check("t1_bank0_a0", mem_a[0][0], 1);
        check("t1_bank0_a1", mem_a[0][1], 2);
        check("t1_bank0_a2", mem_a[0][2], 3);
        check("t1_bank1_b0", mem_b[1][0], 11);
        check("t1_len_err", len_err, 1'b0);

        // Random valid gaps give the same bank image
        clear_mem();
        start_job();
        load_job(1'b1, 17, 18);
        finish_job(1'b0);
        check_mem("t2_mem");

        // Early s_last on A's last beat: error set, job still completes
        start_job();
        load_job(1'b0, 8, 18);
        finish_job(1'b0);
        check("t4_len_err_sticky", len_err, 1'b1);
        start_job();
        // Missing s_last on the final B beat
        load_job(1'b0, -1, 18);
        finish_job(1'b0);
        check("t4_len_err_missing", len_err, 1'b1);

        // Reset while B beat 4 is presented
        start_job();
        load_job(1'b0, 17, 13);
        s_valid = 1'b1;
        s_data  = 16'd14;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {s_ready, ctrl_start, busy, job_done, len_err}, 5'b0);
        check("t5_rst_en", {en_a_brams, we_a_brams, en_b_brams, we_b_brams}, 12'h0);
        check("t5_rst_addr", {addr_a_brams, addr_b_brams}, 12'h0);
        check("t5_rst_din", {din_a_brams[15:0], din_b_brams[15:0]}, 32'h0);
        check("t5_sb_empty", sb.size(), 0);
        s_valid = 1'b0;
        tick();
        check("t5_no_write", {en_a_brams, en_b_brams}, 6'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        clear_mem();
        start_job();
        load_job(1'b0, 17, 18);
        finish_job(1'b0);
        check_mem("t5_mem");
        check("t5_len_err", len_err, 1'b0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
